// File: rtl/axioma_ldst_unit.sv
// Load/store unit: one pointer-based access per request, plus the optional
// X/Y/Z post-increment or pre-decrement writeback and the LD register write.
module axioma_ldst_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op_store,
  input  logic [1:0]  ptr_sel,
  input  logic [1:0]  mode,
  input  logic [5:0]  disp,
  input  logic [4:0]  reg_addr,
  input  logic [7:0]  store_data,
  input  logic [15:0] x_ptr,
  input  logic [15:0] y_ptr,
  input  logic [15:0] z_ptr,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [4:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_write_en,
  output logic [15:0] ptr_out,
  output logic        x_write_en,
  output logic        y_write_en,
  output logic        z_write_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB} state_t;
  typedef enum logic [1:0] {M_PLAIN, M_POSTINC, M_PREDEC, M_DISP} mode_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_op_store;
  logic [1:0]  r_ptr_sel;
  mode_t       r_mode;
  logic [5:0]  r_disp;
  logic [4:0]  r_reg_addr;
  logic [7:0]  r_store_data;
  logic [15:0] r_ptr;
  logic [7:0]  r_rdata;
  logic        r_err;

  logic        w_illegal;
  logic [15:0] w_sel_ptr;
  logic [15:0] w_ea;
  logic        w_upd;
  logic [15:0] w_new_ptr;
  logic        w_pair_hit;

  assign w_illegal = (ptr_sel == 2'd3) || ((mode == 2'd3) && (ptr_sel == 2'd0));

  always_comb begin
    w_sel_ptr = '0;
    case (ptr_sel)
      2'd0:    w_sel_ptr = x_ptr;
      2'd1:    w_sel_ptr = y_ptr;
      2'd2:    w_sel_ptr = z_ptr;
      default: w_sel_ptr = '0;
    endcase
  end

  always_comb begin
    w_ea = r_ptr;
    case (r_mode)
      M_PREDEC: w_ea = r_ptr - 16'd1;
      M_DISP:   w_ea = r_ptr + {10'd0, r_disp};
      default:  w_ea = r_ptr;
    endcase
  end

  assign w_upd     = (r_mode == M_POSTINC) || (r_mode == M_PREDEC);
  assign w_new_ptr = (r_mode == M_PREDEC) ? (r_ptr - 16'd1) : (r_ptr + 16'd1);
  // Pointer pairs sit at R26/27 (X), R28/29 (Y), R30/31 (Z): pair index 13+sel.
  assign w_pair_hit = (r_reg_addr[4:1] == (4'd13 + {2'b00, r_ptr_sel}));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op_store   <= 1'b0;
      r_ptr_sel    <= '0;
      r_mode       <= M_PLAIN;
      r_disp       <= '0;
      r_reg_addr   <= '0;
      r_store_data <= '0;
      r_ptr        <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        if (w_illegal) begin
          r_err <= 1'b1;
        end else begin
          r_op_store   <= op_store;
          r_ptr_sel    <= ptr_sel;
          r_mode       <= mode_t'(mode);
          r_disp       <= disp;
          r_reg_addr   <= reg_addr;
          r_store_data <= store_data;
          r_ptr        <= w_sel_ptr;
        end
      end
      if ((r_state == S_ACCESS) && mem_ack && !r_op_store) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // Outputs are also forced low while reset_n is held, not only after the edge.
  always_comb begin
    w_next      = r_state;
    mem_addr    = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    rd_addr     = '0;
    rd_data     = '0;
    rd_write_en = 1'b0;
    ptr_out     = '0;
    x_write_en  = 1'b0;
    y_write_en  = 1'b0;
    z_write_en  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    if (reset_n) begin
      err = r_err;
      case (r_state)
        S_IDLE: begin
          if (start && !w_illegal) w_next = S_ACCESS;
        end
        S_ACCESS: begin
          busy      = 1'b1;
          mem_req   = 1'b1;
          mem_addr  = w_ea;
          mem_we    = r_op_store;
          mem_wdata = r_store_data;
          if (mem_ack) w_next = S_WB;
        end
        S_WB: begin
          busy   = 1'b1;
          done   = 1'b1;
          w_next = S_IDLE;
          if (!r_op_store) begin
            rd_addr     = r_reg_addr;
            rd_data     = r_rdata;
            rd_write_en = !(w_upd && w_pair_hit);
          end
          if (w_upd) begin
            ptr_out = w_new_ptr;
            case (r_ptr_sel)
              2'd0:    x_write_en = 1'b1;
              2'd1:    y_write_en = 1'b1;
              2'd2:    z_write_en = 1'b1;
              default: ;
            endcase
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

endmodule
